// File: rtl/neuron.sv
// Leaky integrate-and-fire neuron: one leak/accumulate/threshold step per start pulse,
// emitting a one-cycle spike strobe and {id, timestamp} packet toward the mesh router.
//
// state | meaning
// IDLE  | waiting for start
// LEAK  | V <= V - (V >>> LEAK_SHIFT), idx cleared
// ACC   | one synapse per cycle, saturating add for active synapses
// CHECK | threshold compare, optional spike, timestamp advance
module neuron #(
   parameter logic [15:0]          NEURON_ID  = 16'h0001,
   parameter int                   N_SYN      = 8,
   parameter logic [16*N_SYN-1:0]  WEIGHTS    = {N_SYN{16'sd40}},
   parameter logic [N_SYN-1:0]     INPUT_MASK = {N_SYN{1'b1}},
   parameter logic signed [15:0]   THRESHOLD  = 16'sd600,
   parameter int                   LEAK_SHIFT = 3,
   parameter logic signed [15:0]   V_RESET    = 16'sd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] SpikePacket,
   output logic        outSpike,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, LEAK, ACC, CHECK} state_t;

   // Widened copies so a 4-bit idx selects without width mismatch for any N_SYN.
   localparam logic [255:0] W_ALL    = 256'(WEIGHTS);
   localparam logic [15:0]  MASK_ALL = 16'(INPUT_MASK);
   localparam logic [3:0]   LAST_IDX = 4'(N_SYN - 1);

   state_t             state;
   logic signed [15:0] v_mem;
   logic [15:0]        ts;
   logic [3:0]         idx;

   logic signed [15:0] w_sel;
   logic signed [16:0] sum_ext;
   logic signed [15:0] sum_sat;
   logic signed [15:0] v_leak;

   always_comb begin
      w_sel   = W_ALL[{idx, 4'b0000} +: 16];
      sum_ext = {v_mem[15], v_mem} + {w_sel[15], w_sel};
      sum_sat = sum_ext[15:0];
      if (sum_ext[16] != sum_ext[15])
         sum_sat = sum_ext[16] ? 16'sh8000 : 16'sh7FFF;
      v_leak  = v_mem - (v_mem >>> LEAK_SHIFT);
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         v_mem       <= '0;
         ts          <= '0;
         idx         <= '0;
         outSpike    <= 1'b0;
         SpikePacket <= '0;
      end else begin
         outSpike <= 1'b0;
         case (state)
            IDLE: begin
               if (start)
                  state <= LEAK;
            end
            LEAK: begin
               v_mem <= v_leak;
               idx   <= '0;
               state <= ACC;
            end
            ACC: begin
               if (MASK_ALL[idx])
                  v_mem <= sum_sat;
               idx <= idx + 4'd1;
               if (idx == LAST_IDX)
                  state <= CHECK;
            end
            CHECK: begin
               if (v_mem >= THRESHOLD) begin
                  outSpike    <= 1'b1;
                  SpikePacket <= {NEURON_ID, ts};
                  v_mem       <= V_RESET;
               end
               ts    <= ts + 16'd1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron.sv
// Bench for neuron: table of default-parameter steps checked through a scoreboard queue,
// plus hand sequences for start-while-busy, saturation and mid-step reset.
module tb_neuron;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start_s = 1'b0;
   logic [31:0] pkt, pkt_s;
   logic        spk, spk_s;
   logic        busy, busy_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   neuron dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .SpikePacket(pkt), .outSpike(spk), .busy(busy)
   );

   neuron #(.WEIGHTS({8{16'sd20000}}), .INPUT_MASK(8'hFF)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start_s),
      .SpikePacket(pkt_s), .outSpike(spk_s), .busy(busy_s)
   );

   typedef struct {
      bit                 spike;
      logic [31:0]        pkt;
      logic signed [15:0] v_after;
   } vec_t;

   vec_t tbl[6];
   vec_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one start pulse and watches the step to completion (sampling at negedges).
   task automatic run_step(output bit spiked, output int lat, output int done_n,
                           output logic [31:0] spkt);
      spiked = 0; lat = -1; done_n = -1; spkt = '0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (spk && !spiked) begin
            spiked = 1; lat = n; spkt = pkt;
         end
         if (!busy) begin
            done_n = n;
            break;
         end
      end
      if (done_n < 0) check("step_timeout", 32'd0, 32'd1);
      @(negedge clk);
      check("spike_one_cycle", 32'(spk), 32'd0);
   endtask

   task automatic step_and_score(input string name);
      bit spiked; int lat, done_n; logic [31:0] spkt;
      vec_t e;
      run_step(spiked, lat, done_n, spkt);
      e = sb.pop_front();
      check({name, "_spike"}, 32'(spiked), 32'(e.spike));
      check({name, "_done_lat"}, 32'(done_n), 32'd10);
      if (e.spike) begin
         check({name, "_spike_lat"}, 32'(lat), 32'd10);
         check({name, "_pkt"}, spkt, e.pkt);
      end
      check({name, "_pkt_hold"}, pkt, e.pkt);
      check({name, "_v"}, 32'(dut.v_mem), 32'(e.v_after));
   endtask

   initial begin
      int  n;
      bit  got_spike, went_neg, seen_busy;
      logic signed [15:0] vmax;

      // {spike, latest packet, V after}
      tbl[0] = '{1'b0, 32'h0000_0000, 16'sd320};
      tbl[1] = '{1'b1, 32'h0001_0001, 16'sd0};
      tbl[2] = '{1'b0, 32'h0001_0001, 16'sd320};
      tbl[3] = '{1'b1, 32'h0001_0003, 16'sd0};
      tbl[4] = '{1'b1, 32'h0001_0005, 16'sd0};
      tbl[5] = '{1'b1, 32'h0001_0001, 16'sd0};

      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_spike", 32'(spk), 32'd0);
         check("rst_pkt", pkt, 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_spike", 32'(spk), 32'd0);

      for (int i = 0; i < 4; i++) begin
         sb.push_back(tbl[i]);
         step_and_score($sformatf("step%0d", i + 1));
      end

      // start re-pulsed three cycles into a step must be dropped
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("busy_step_ends", 32'(busy), 32'd0);
      seen_busy = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy) seen_busy = 1;
      end
      check("ignored_start", 32'(seen_busy), 32'd0);
      check("ts_after_ignored", 32'(dut.ts), 32'd5);
      sb.push_back(tbl[4]);
      step_and_score("step6");

      // saturation on the high-weight instance
      got_spike = 0; went_neg = 0; vmax = 16'sh8000;
      @(negedge clk) start_s = 1'b1;
      @(negedge clk) start_s = 1'b0;
      n = 0;
      while (busy_s && n < 40) begin
         @(negedge clk);
         n++;
         if (dut_sat.v_mem < 0) went_neg = 1;
         if (dut_sat.v_mem > vmax) vmax = dut_sat.v_mem;
         if (spk_s) got_spike = 1;
      end
      check("sat_done", 32'(busy_s), 32'd0);
      check("sat_no_wrap", 32'(went_neg), 32'd0);
      check("sat_clamp", 32'(vmax), 32'(16'sd32767));
      check("sat_spike", 32'(got_spike), 32'd1);
      check("sat_pkt", pkt_s, 32'h0001_0000);

      // reset dropped during ACC
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_spike", 32'(spk), 32'd0);
      check("mid_rst_pkt", pkt, 32'd0);
      check("mid_rst_v", 32'(dut.v_mem), 32'd0);
      check("mid_rst_ts", 32'(dut.ts), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      sb.push_back('{1'b0, 32'h0000_0000, 16'sd320});
      step_and_score("post_rst1");
      sb.push_back(tbl[5]);
      step_and_score("post_rst2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/neuron.md
# neuron

Single leaky integrate-and-fire neuron that performs one discrete time step per `start` pulse. Each step applies a shift-based leak to a signed membrane potential, accumulates the weights of the active synapses one per cycle, and compares the result against a threshold. On a threshold crossing it emits a one-cycle `outSpike` write strobe and a 32-bit spike packet, which feed the local input port of the mesh router.

## Interface
Parameters:
- `NEURON_ID`, 16'h0001: source address placed in packet bits [31:16].
- `N_SYN`, 8: number of synapses (1..16).
- `WEIGHTS`, {8{16'sd40}}: packed signed 16-bit weights; synapse i occupies bits [16i+15:16i].
- `INPUT_MASK`, 8'hFF: bit i set means synapse i is active every step.
- `THRESHOLD`, 16'sd600: signed firing threshold.
- `LEAK_SHIFT`, 3: leak amount is V >>> LEAK_SHIFT.
- `V_RESET`, 16'sd0: potential loaded after firing.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request one time step; sampled only in IDLE.
- `SpikePacket` output 32: {NEURON_ID, timestamp[15:0]} of the most recent spike; holds its value between spikes.
- `outSpike` output 1: one-cycle write strobe to the router, asserted when a spike is emitted.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- State: V (signed 16-bit membrane potential), ts (16-bit step counter), syn index, FSM with states IDLE, LEAK, ACC, CHECK.
- IDLE: if `start`=1 at a clock edge, go to LEAK. Otherwise stay in IDLE.
- LEAK: V <= V - (V >>>> LEAK_SHIFT), using an arithmetic shift. Set idx <= 0, then go to ACC.
- ACC: if INPUT_MASK[idx]=1, V <= sat16(V + W[idx]). Increment idx. After idx = N_SYN-1 is processed, go to CHECK. ACC lasts exactly N_SYN cycles whether or not a synapse is masked.
- CHECK, when V >= THRESHOLD (signed compare):
  - outSpike <= 1
  - SpikePacket <= {NEURON_ID, ts}
  - V <= V_RESET
- CHECK, always:
  - ts <= ts + 1, wrapping from 16'hFFFF to 0.
  - Go to IDLE.
- outSpike is a registered output. It is cleared on every edge except a firing CHECK edge.
- sat16 clamps the result to [-32768, 32767].
- `start` pulses that arrive outside IDLE are ignored. They are not queued.
- If `start` is held high, steps run back-to-back: each new step begins on the first edge after CHECK.
- rst_n=0, including mid-step, asynchronously clears all state:
  - V=0, ts=0, idx=0
  - FSM=IDLE
  - outSpike=0, SpikePacket=0, busy=0
- After rst_n is released, the first `start` is honoured on the first rising edge at which it is sampled high.

## Timing
- `start` sampled high in IDLE at edge k. Subsequent edges:
  - k+1: LEAK
  - k+2 .. k+1+N_SYN: ACC
  - k+2+N_SYN: CHECK
- outSpike is high from edge k+2+N_SYN to edge k+3+N_SYN. That is exactly one cycle; latency is N_SYN+2 cycles (10 at defaults).
- SpikePacket changes only at a firing CHECK edge and is valid no later than outSpike rising.
- busy is high from edge k to edge k+2+N_SYN.
- Reset values of all outputs: outSpike=0, SpikePacket=32'h0, busy=0.

## Test plan
- Reset then idle: rst_n low for 2 cycles, no start. Require outSpike=0, SpikePacket=0, busy=0 throughout.
- Two steps, defaults:
  - Step 1: V goes 0 -> 320, below threshold, no spike.
  - Step 2: leak gives 280, accumulation gives 600 >= 600, so outSpike pulses for one cycle, 10 cycles after start is sampled. SpikePacket=32'h0001_0001, and V returns to 0.
- Steps 3 and 4: no spike on step 3; spike on step 4 with SpikePacket=32'h0001_0003. This confirms the post-fire reset and ts counting.
- Start while busy: pulse start again 3 cycles after the first start. Require it to be ignored: ts advances by exactly 1, and there is one CHECK only.
- Saturation: set WEIGHTS to all 16'sd20000 and INPUT_MASK=8'hFF. Require V to clamp at 32767 during ACC, with no wrap to negative, and a spike to be emitted.
- Reset mid-step: drop rst_n during ACC. Require busy=0 and outSpike=0 immediately, and V=0 and ts=0. The next step behaves as step 1.
